// File: rtl/cg_ctrl_pkg.sv
// cg_ctrl_pkg: shared FSM state type and default counter width for the clock-gate enable controller
package cg_ctrl_pkg;
   typedef enum logic [1:0] {CG_RUN, CG_GATED, CG_WAKE} cg_state_t;
   localparam int CG_CNT_W_DEF = 8;
endpackage

// File: rtl/cg_sat_counter.sv
// cg_sat_counter: saturating up-counter with synchronous clear taking priority over increment
module cg_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;
   // clear wins; increment stops at all-ones
   always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   // count register
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/cg_enable_ctrl.sv
// cg_enable_ctrl: registered ICG enable that gates after an idle run and acks wake-up once the clock is stable
// Optional gated-cycle statistics (stat_clr, gated_cycles) are built when CG_STATS_EN is defined.
module cg_enable_ctrl
   import cg_ctrl_pkg::*;
#(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_DELAY  = 2,
   parameter int CNT_W       = CG_CNT_W_DEF
`ifdef CG_STATS_EN
   ,parameter int STAT_W     = 32
`endif
) (
   input  logic              CK,
   input  logic              RN,
   input  logic              busy,
   input  logic              wake_req,
   input  logic              force_on,
   output logic              E,
   output logic              gated,
   output logic              wake_ack
`ifdef CG_STATS_EN
   ,input  logic             stat_clr,
   output logic [STAT_W-1:0] gated_cycles
`endif
);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DELAY - 1);
   cg_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             e_q, e_d, gated_q, gated_d, ack_q, ack_d;
   logic             wake;
   assign wake = busy | wake_req | force_on;
   // next-state and registered-output decode; wake sources dominate the idle count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      e_d     = e_q;
      gated_d = gated_q;
      ack_d   = 1'b0;
      case (state_q)
         CG_RUN: begin
            e_d     = 1'b1;
            gated_d = 1'b0;
            cnt_d   = (wake || cnt_q == IDLE_LAST) ? '0 : cnt_q + 1'b1;
            if (!wake && cnt_q == IDLE_LAST) begin
               state_d = CG_GATED;
               e_d     = 1'b0;
               gated_d = 1'b1;
            end
         end
         CG_GATED: begin
            if (wake) begin
               state_d = CG_WAKE;
               e_d     = 1'b1;
               gated_d = 1'b0;
               cnt_d   = '0;
            end
         end
         CG_WAKE: begin
            cnt_d = (cnt_q == WAKE_LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == WAKE_LAST) begin
               state_d = CG_RUN;
               ack_d   = 1'b1;
            end
         end
         default: begin
            state_d = CG_RUN;
            e_d     = 1'b1;
            gated_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end
   // state and output registers; E held high in reset so downstream logic still sees a clock
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= CG_RUN;
         cnt_q   <= '0;
         e_q     <= 1'b1;
         gated_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
         gated_q <= gated_d;
         ack_q   <= ack_d;
      end
   end
   assign E        = e_q;
   assign gated    = gated_q;
   assign wake_ack = ack_q;
`ifdef CG_STATS_EN
   cg_sat_counter #(.W(STAT_W)) u_stat (
      .clk_i  (CK),
      .rst_ni (RN),
      .clr_i  (stat_clr),
      .inc_i  (gated_q),
      .cnt_o  (gated_cycles)
   );
`endif
endmodule
